// File: rtl/nn_seq_top_pkg.sv
// Shared types and constants for the sequential NN engine.
// Fixed-point format, saturation bounds, activation codes, FSM states.
package nn_seq_top_pkg;

  localparam int N = 16;
  localparam int F = 8;

  localparam int SAT_MAX = (1 << (N - 1)) - 1;
  localparam int SAT_MIN = -(1 << (N - 1));

  localparam int ACT_RELU = 0;
  localparam int ACT_LIN  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MAC,
    S_WB,
    S_DONE
  } state_e;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nn_seq_top_mac_lane.sv
// One MAC lane: accumulator, multiply-add, rescale, saturate, activate.
// Ports: init_i/mac_i control, bias_i/a_i/w_i data, res_o result, sat_o clip.
module nn_seq_top_mac_lane
  import nn_seq_top_pkg::*;
#(
  parameter int AccW = 36
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_i,
  input  logic                mac_i,
  input  logic                relu_i,
  input  logic signed [N-1:0] bias_i,
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] w_i,
  output logic signed [N-1:0] res_o,
  output logic                sat_o
);

  localparam logic signed [AccW-1:0] HI = AccW'(SAT_MAX);
  localparam logic signed [AccW-1:0] LO = AccW'(SAT_MIN);

  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] acc_d;
  logic signed [AccW-1:0] sh;
  logic signed [2*N-1:0]  prod;
  logic signed [N-1:0]    res;

  always_comb begin
    prod  = a_i * w_i;
    acc_d = acc_q;
    if (init_i) begin
      acc_d = AccW'(bias_i) <<< F;
    end else if (mac_i) begin
      acc_d = acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    sh    = acc_q >>> F;
    sat_o = 1'b0;
    res   = sh[N-1:0];
    if (sh > HI) begin
      res   = N'(SAT_MAX);
      sat_o = 1'b1;
    end else if (sh < LO) begin
      res   = N'(SAT_MIN);
      sat_o = 1'b1;
    end
    if (relu_i && res[N-1]) begin
      res = '0;
    end
    res_o = res;
  end

endmodule

// File: rtl/nn_seq_top.sv
// Sequential NL-layer fully-connected network on a shared bank of NMAX lanes.
// Ports: clk/rst, wr_* weight port, start/x_in, busy/done/y_out/sat/wr_err.
module nn_seq_top
  import nn_seq_top_pkg::*;
#(
  parameter int              NX    = 4,
  parameter int              NL    = 3,
  parameter int              NMAX  = 8,
  parameter logic [8*NL-1:0] LSIZE = {8'd2, 8'd8, 8'd8},
  parameter int              ACT   = 0,
  localparam int             KMAX  = imax(NX, NMAX),
  localparam int             AW    = $clog2(NL * NMAX * (KMAX + 1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              start,
  input  logic [N*NX-1:0]   x_in,
  output logic              busy,
  output logic              done,
  output logic [N*NMAX-1:0] y_out,
  output logic              sat,
  output logic              wr_err
);

  localparam int DEPTH = NL * NMAX * (KMAX + 1);
  localparam int AccW  = 2 * N + $clog2(KMAX + 1);
  localparam int KIW   = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam int LW    = (NL > 1) ? $clog2(NL) : 1;

  state_e state_q;

  logic [LW-1:0]  l_q;
  logic [KIW-1:0] k_q;
  logic           busy_q;
  logic           done_q;
  logic           sat_q;
  logic           wr_err_q;

  logic signed [N-1:0] w_q   [DEPTH];
  logic signed [N-1:0] x_q   [NX];
  logic signed [N-1:0] act_q [NMAX];
  logic signed [N-1:0] y_q   [NMAX];

  logic [7:0]          kl;
  logic [7:0]          lsz;
  logic                last_k;
  logic                last_l;
  logic                relu;
  logic signed [N-1:0] avec [KMAX];
  logic signed [N-1:0] a_sel;
  logic                wr_ok;

  logic [NMAX-1:0]     lvalid;
  logic [NMAX-1:0]     lsat;
  logic signed [N-1:0] lres [NMAX];

  always_comb begin
    kl = 8'(NX);
    if (l_q != '0) begin
      kl = LSIZE[8*(int'(l_q)-1) +: 8];
    end
    lsz    = LSIZE[8*int'(l_q) +: 8];
    last_k = (8'(k_q) == kl - 8'd1);
    last_l = (int'(l_q) == NL - 1);
    relu   = (ACT == ACT_RELU) && !last_l;
    wr_ok  = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  end

  // Layer 0 consumes the latched inputs, later layers the prior activations.
  always_comb begin
    for (int i = 0; i < KMAX; i++) begin
      avec[i] = '0;
    end
    if (l_q == '0) begin
      for (int i = 0; i < NX; i++) begin
        avec[i] = x_q[i];
      end
    end else begin
      for (int i = 0; i < NMAX; i++) begin
        avec[i] = act_q[i];
      end
    end
  end

  assign a_sel = avec[k_q];

  for (genvar j = 0; j < NMAX; j++) begin : g_lane
    logic [AW-1:0] widx;
    logic [AW-1:0] bidx;

    always_comb begin
      widx = AW'((int'(l_q) * NMAX + j) * (KMAX + 1) + int'(k_q));
      bidx = AW'((int'(l_q) * NMAX + j) * (KMAX + 1) + KMAX);
    end

    assign lvalid[j] = (j < int'(lsz));

    nn_seq_top_mac_lane #(
      .AccW(AccW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst),
      .init_i(state_q == S_INIT),
      .mac_i (state_q == S_MAC),
      .relu_i(relu),
      .bias_i(w_q[bidx]),
      .a_i   (a_sel),
      .w_i   (w_q[widx]),
      .res_o (lres[j]),
      .sat_o (lsat[j])
    );

    assign y_out[j*N +: N] = y_q[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      l_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) w_q[i] <= '0;
      for (int i = 0; i < NX; i++) x_q[i] <= '0;
      for (int i = 0; i < NMAX; i++) begin
        act_q[i] <= '0;
        y_q[i]   <= '0;
      end
    end else begin
      done_q <= 1'b0;

      if (wr_en) begin
        if (busy_q) begin
          wr_err_q <= 1'b1;
        end else if (wr_ok) begin
          w_q[wr_addr] <= wr_data;
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NX; i++) begin
              x_q[i] <= x_in[i*N +: N];
            end
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            l_q     <= '0;
            k_q     <= '0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          k_q     <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          if (last_k) begin
            state_q <= S_WB;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_WB: begin
          for (int i = 0; i < NMAX; i++) begin
            act_q[i] <= lvalid[i] ? lres[i] : '0;
          end
          if (|(lsat & lvalid)) begin
            sat_q <= 1'b1;
          end
          k_q <= '0;
          if (last_l) begin
            for (int i = 0; i < NMAX; i++) begin
              y_q[i] <= lvalid[i] ? lres[i] : '0;
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            l_q     <= l_q + 1'b1;
            state_q <= S_INIT;
          end
        end
        S_DONE: begin
          l_q     <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign sat    = sat_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_nn_seq_top.sv
// Directed bench for nn_seq_top: ReLU and linear instances share stimulus.
// Fixed point Q8.8: 1.0 = 256.
module tb_nn_seq_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         start;
  logic [63:0]  x_in;
  logic         busy0, done0, sat0, err0;
  logic         busy1, done1, sat1, err1;
  logic [127:0] y0, y1;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int cyc;
  int dn;

  localparam logic [63:0] X1 = {16'd768, 16'hFF00, 16'd512, 16'd256};
  localparam logic [63:0] X2 = {16'd768, 16'hFF00, 16'd512, 16'hFF00};
  localparam logic [63:0] XS = {4{16'h7FFF}};

  always #5 clk = ~clk;

  nn_seq_top #(.ACT(0)) dut0 (
    .clk(clk), .rst(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .x_in(x_in), .busy(busy0),
    .done(done0), .y_out(y0), .sat(sat0), .wr_err(err0)
  );

  nn_seq_top #(.ACT(1)) dut1 (
    .clk(clk), .rst(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .x_in(x_in), .busy(busy1),
    .done(done1), .y_out(y1), .sat(sat1), .wr_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ad(int l, int n, int k);
    return 8'((l * 8 + n) * 9 + k);
  endfunction

  task automatic wr(input int l, input int n, input int k,
                    input logic [15:0] d);
    wr_addr = ad(l, n, k);
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 216; a++) begin
      wr_addr = 8'(a);
      wr_data = '0;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic ident();
    for (int j = 0; j < 4; j++) wr(0, j, j, 16'd256);
    for (int j = 0; j < 8; j++) wr(1, j, j, 16'd256);
    for (int j = 0; j < 2; j++) wr(2, j, j, 16'd256);
  endtask

  // Start counts as edge 1; returns in the first IDLE cycle after done.
  task automatic run(input logic [63:0] x, output int c);
    x_in  = x;
    start = 1'b1;
    c     = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      c++;
      if (done0) break;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    start   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    x_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_y", 32'(y0 != '0), 32'd0);
    chk("rst_sat", 32'(sat0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ident();
    run(X1, cyc);
    chk("id_lat", 32'(cyc), 32'd27);
    chk("id_y0", {16'h0, y0[15:0]}, 32'h0100);
    chk("id_y1", {16'h0, y0[31:16]}, 32'h0200);
    chk("id_yhi", 32'(y0[127:32] != '0), 32'd0);
    chk("id_sat", 32'(sat0), 32'd0);
    chk("id_busy", 32'(busy0), 32'd0);
    chk("id_lin_y0", {16'h0, y1[15:0]}, 32'h0100);

    wr(2, 0, 8, 16'd128);
    run(X2, cyc);
    chk("relu_y0", {16'h0, y0[15:0]}, 32'h0080);
    chk("relu_y1", {16'h0, y0[31:16]}, 32'h0200);
    chk("lin_y0", {16'h0, y1[15:0]}, 32'hFF80);

    wr_addr = ad(2, 0, 8);
    wr_data = 16'd384;
    wr_en   = 1'b1;
    run(X2, cyc);
    chk("bnd_lat", 32'(cyc), 32'd27);
    chk("bnd_y0", {16'h0, y0[15:0]}, 32'h0180);
    chk("bnd_lin_y0", {16'h0, y1[15:0]}, 32'h0080);

    run(X1, cyc);
    chk("b2b_lat", 32'(cyc), 32'd27);
    chk("b2b_y0", {16'h0, y0[15:0]}, 32'h0280);

    x_in  = X1;
    start = 1'b1;
    dn    = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (done0) dn++;
      if (i == 4) begin
        start   = 1'b1;
        wr_addr = ad(2, 0, 8);
        wr_data = 16'd999;
        wr_en   = 1'b1;
      end
    end
    chk("hs_dones", 32'(dn), 32'd1);
    chk("hs_err", 32'(err0), 32'd1);
    chk("hs_busy", 32'(busy0), 32'd0);
    chk("hs_y0", {16'h0, y0[15:0]}, 32'h0280);
    run(X1, cyc);
    chk("hs_keep_y0", {16'h0, y0[15:0]}, 32'h0280);

    clear_all();
    for (int l = 0; l < 3; l++)
      for (int n = 0; n < 8; n++)
        for (int k = 0; k < 8; k++)
          wr(l, n, k, 16'h7FFF);
    run(XS, cyc);
    chk("sat_y0", {16'h0, y0[15:0]}, 32'h7FFF);
    chk("sat_y1", {16'h0, y0[31:16]}, 32'h7FFF);
    chk("sat_yhi", 32'(y0[127:32] != '0), 32'd0);
    chk("sat_flag", 32'(sat0), 32'd1);
    chk("sat_lin_flag", 32'(sat1), 32'd1);

    clear_all();
    ident();
    run(X1, cyc);
    chk("nsat_y0", {16'h0, y0[15:0]}, 32'h0100);
    chk("nsat_flag", 32'(sat0), 32'd0);

    x_in  = X1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy0), 32'd0);
    chk("mr_done", 32'(done0), 32'd0);
    chk("mr_y", 32'(y0 != '0), 32'd0);
    chk("mr_err", 32'(err0), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ident();
    run(X1, cyc);
    chk("mr_lat", 32'(cyc), 32'd27);
    chk("mr_y0", {16'h0, y0[15:0]}, 32'h0100);
    chk("mr_y1", {16'h0, y0[31:16]}, 32'h0200);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
